lsu_rmw: RTL and testbench
==========================

# lsu_rmw

Load/store unit between the EX/MEM pipeline register and the byte-addressed 64-bit data memory. Drives the memory's address, write-data, read and write strobes. Performs sign- or zero-extension on loads (lb/lh/lw/ld/lbu/lhu/lwu). Turns sub-doubleword stores (sb/sh/sw), which the memory cannot do natively, into a two-cycle read-modify-write, stalling the pipeline for one cycle.

## Interface
- MEM_BYTES, 256, data memory size in bytes; legal access addresses are 0..MEM_BYTES-8.
- Reset rst_i is asynchronous, active-low; clock is clk_i.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- req_read_i  in  1  load request from MEM stage.
- req_write_i  in  1  store request from MEM stage.
- funct3_i  in  3  RV64 funct3 of the load/store.
- addr_i  in  64  byte address, unsigned.
- wdata_i  in  64  store data (rs2 value).
- rdata_o  out  64  extended load result to MEM/WB.
- stall_o  out  1  hold the pipeline; the request must stay stable while high.
- fault_o  out  1  illegal access in the current cycle.
- mem_addr_o  out  64  memory address.
- mem_wdata_o  out  64  memory write data.
- mem_read_o  out  1  memory read strobe.
- mem_write_o  out  1  memory write strobe.
- mem_rdata_i  in  64  memory read data (combinational from mem_addr_o).
- rmw_cnt_o  out  16  completed RMW stores, saturating.

## Operation
- FSM states: IDLE and MERGE. Register merge_q holds 64 bits.
- Fault (combinational, only in IDLE) is raised by any of:
  - req_read_i and req_write_i both high;
  - addr_i > MEM_BYTES-8 (64-bit unsigned compare) while either request is high;
  - load with funct3=111;
  - store with funct3[2]=1.
- On fault: no strobe is asserted, rdata_o=0, stall_o=0, state stays IDLE.
- Load, IDLE:
  - mem_read_o=1, mem_addr_o=addr_i.
  - rdata_o = mem_rdata_i extended per funct3: 000 sext byte, 001 sext half, 010 sext word, 011 double, 100 zext byte, 101 zext half, 110 zext word.
  - No stall.
- sd (funct3=011), IDLE: mem_write_o=1, mem_wdata_o=wdata_i, no stall, write occurs at the next edge.
- sb/sh/sw, IDLE:
  - mem_read_o=1, mem_addr_o=addr_i, stall_o=1.
  - At the edge: merge_q <= mem_rdata_i, state -> MERGE.
- MERGE:
  - mem_write_o=1, mem_addr_o=addr_i, stall_o=0.
  - mem_wdata_o = merge_q with its low 1/2/4 bytes (sb/sh/sw) replaced by the low bytes of wdata_i.
  - At the edge: state -> IDLE, rmw_cnt_o increments unless at 16'hFFFF.
- No request and no fault: all strobes 0, rdata_o=0, mem_addr_o=addr_i, mem_wdata_o=wdata_i.
- Request inputs are ignored in MERGE apart from addr_i, wdata_i and funct3_i, which the pipeline holds stable.

## Timing
- Reset values: state IDLE, merge_q 0, rmw_cnt_o 0, stall_o 0, mem_write_o 0, mem_read_o 0, fault_o 0.
- Loads: 0-cycle latency, rdata_o valid in the request cycle.
- sd: 1 cycle, no stall.
- sb/sh/sw: 2 cycles, stall_o high exactly 1 cycle. The memory is written at the end of the second cycle.
- Back-to-back sub-word stores: the second request is accepted in the cycle after MERGE. No bubble beyond its own stall.
- Reset asserted in MERGE: state returns to IDLE immediately, no memory write is issued, rmw_cnt_o is unchanged from 0.
- Counter at 16'hFFFF stays at 16'hFFFF.

## Test plan
- Memory doubleword at 0x10 preloaded to 64'h8877665544332211.
  - lb → rdata_o=64'h0000000000000011.
  - lh at 0x17 faults? No: 0x17 ≤ 248, so the read is legal.
  - lw at 0x14 with byte 0x17 = 0x88 → rdata_o=64'hFFFFFFFF88776655.
  - lwu at 0x14 → 64'h0000000088776655.
- sb 0xAB to 0x10 with the above contents:
  - stall_o=1 for one cycle.
  - Then mem_wdata_o=64'h88776655443322AB with mem_write_o=1.
  - rmw_cnt_o becomes 1.
- sd 64'hDEADBEEFCAFEF00D at 0x20:
  - single-cycle write, stall_o stays 0.
  - A following ld at 0x20 returns the same value.
- Fault cases:
  - ld at addr 249 → fault_o=1, no strobes, rdata_o=0.
  - Load with funct3=111 → fault_o=1.
  - Both requests high → fault_o=1.
- Reset mid-operation: sh issued, rst_i pulsed low during MERGE → mem_write_o drops to 0 immediately, memory unchanged, state IDLE, rmw_cnt_o=0.
- Back-to-back sw at 0x00 then sw at 0x08:
  - Two stall cycles total.
  - Both merged writes are correct.
  - rmw_cnt_o=2.

Source files
------------

// File: rtl/lsu_rmw_if.sv
// lsu_rmw bus bundle: MEM-stage request side and data memory side.
// slave is the LSU; master is the pipeline/memory environment.
interface lsu_rmw_if;
  logic        req_read_i;
  logic        req_write_i;
  logic [2:0]  funct3_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic [63:0] rdata_o;
  logic        stall_o;
  logic        fault_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [63:0] mem_rdata_i;
  logic [15:0] rmw_cnt_o;

  modport slave (
    input  req_read_i,
    input  req_write_i,
    input  funct3_i,
    input  addr_i,
    input  wdata_i,
    input  mem_rdata_i,
    output rdata_o,
    output stall_o,
    output fault_o,
    output mem_addr_o,
    output mem_wdata_o,
    output mem_read_o,
    output mem_write_o,
    output rmw_cnt_o
  );

  modport master (
    output req_read_i,
    output req_write_i,
    output funct3_i,
    output addr_i,
    output wdata_i,
    output mem_rdata_i,
    input  rdata_o,
    input  stall_o,
    input  fault_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    input  mem_read_o,
    input  mem_write_o,
    input  rmw_cnt_o
  );
endinterface

// File: rtl/lsu_rmw.sv
// Load/store unit: load extension, native sd, and a two-cycle
// read-modify-write for sb/sh/sw against a doubleword-only memory.
module lsu_rmw #(
  parameter int unsigned MEM_BYTES = 256
) (
  input logic   clk_i,
  input logic   rst_i,
  lsu_rmw_if.slave bus
);
  typedef enum logic {
    IDLE,
    MERGE
  } state_t;

  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  state_t      state_q;
  logic [63:0] merge_q;
  logic [15:0] cnt_q;

  logic        rd;
  logic        wr;
  logic [2:0]  f3;
  logic        idle;
  logic        addr_bad;
  logic        fault;
  logic        ld_ok;
  logic        st_ok;
  logic        sd_ok;
  logic        sub_ok;
  logic        merge_w;
  logic [63:0] ext;
  logic [63:0] merged;
  logic [63:0] md;

  assign rd       = bus.req_read_i;
  assign wr       = bus.req_write_i;
  assign f3       = bus.funct3_i;
  assign md       = bus.mem_rdata_i;
  assign idle     = (state_q == IDLE);
  assign addr_bad = (bus.addr_i > ADDR_MAX);

  // Everything is gated by rst_i so reset quiets the bus at once
  always_comb begin
    fault = rst_i && idle && (
              (rd && wr) ||
              ((rd || wr) && addr_bad) ||
              (rd && (f3 == 3'b111)) ||
              (wr && f3[2]));
    ld_ok   = rst_i && idle && !fault && rd;
    st_ok   = rst_i && idle && !fault && wr;
    sd_ok   = st_ok && (f3 == 3'b011);
    sub_ok  = st_ok && (f3 != 3'b011);
    merge_w = rst_i && (state_q == MERGE);
  end

  always_comb begin
    ext = '0;
    unique case (f3)
      3'b000:  ext = {{56{md[7]}}, md[7:0]};
      3'b001:  ext = {{48{md[15]}}, md[15:0]};
      3'b010:  ext = {{32{md[31]}}, md[31:0]};
      3'b011:  ext = md;
      3'b100:  ext = {56'd0, md[7:0]};
      3'b101:  ext = {48'd0, md[15:0]};
      3'b110:  ext = {32'd0, md[31:0]};
      default: ext = '0;
    endcase
  end

  always_comb begin
    merged = merge_q;
    unique case (1'b1)
      (f3[1:0] == 2'b00): merged[7:0]  = bus.wdata_i[7:0];
      (f3[1:0] == 2'b01): merged[15:0] = bus.wdata_i[15:0];
      (f3[1:0] == 2'b10): merged[31:0] = bus.wdata_i[31:0];
      default:            merged       = bus.wdata_i;
    endcase
  end

  assign bus.mem_addr_o  = bus.addr_i;
  assign bus.mem_wdata_o = merge_w ? merged : bus.wdata_i;
  assign bus.mem_read_o  = ld_ok || sub_ok;
  assign bus.mem_write_o = sd_ok || merge_w;
  assign bus.stall_o     = sub_ok;
  assign bus.fault_o     = fault;
  assign bus.rdata_o     = ld_ok ? ext : '0;
  assign bus.rmw_cnt_o   = cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      merge_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sub_ok) begin
            merge_q <= md;
            state_q <= MERGE;
          end
        end
        MERGE: begin
          state_q <= IDLE;
          if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw: byte-array memory, byte-level
// reference model, directed cases then randomized traffic.
module tb_lsu_rmw;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  always #5 clk_i = ~clk_i;

  lsu_rmw_if bus();

  lsu_rmw #(.MEM_BYTES(256)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  localparam logic [1:0] K_LOAD  = 2'd0;
  localparam logic [1:0] K_WRITE = 2'd1;
  localparam logic [1:0] K_FAULT = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] addr;
    logic [63:0] data;
  } ev_t;

  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  ev_t         exp_q [$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          stall_total = 0;
  logic [15:0] exp_cnt = '0;
  ev_t         mon_a;
  ev_t         mon_e;
  bit          mon_hit;

  always_comb begin
    bus.mem_rdata_i = '0;
    for (int i = 0; i < 8; i++)
      bus.mem_rdata_i[8*i +: 8] =
        mem[(int'(bus.mem_addr_o[7:0]) + i) & 255];
  end

  always @(posedge clk_i) begin
    if (rst_i && bus.mem_write_o)
      for (int i = 0; i < 8; i++)
        mem[(int'(bus.mem_addr_o[7:0]) + i) & 255] <=
          bus.mem_wdata_o[8*i +: 8];
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  // Monitor: classify what the DUT presents, pop and compare.
  always @(negedge clk_i) begin
    if (rst_i) begin
      mon_hit = 1'b1;
      mon_a   = '0;
      if (bus.fault_o) begin
        mon_a.kind = K_FAULT;
        mon_a.addr = {61'd0, bus.mem_read_o,
                      bus.mem_write_o, bus.stall_o};
        mon_a.data = bus.rdata_o;
      end else if (bus.mem_write_o) begin
        mon_a.kind = K_WRITE;
        mon_a.addr = bus.mem_addr_o;
        mon_a.data = bus.mem_wdata_o;
      end else if (bus.mem_read_o && !bus.stall_o) begin
        mon_a.kind = K_LOAD;
        mon_a.addr = bus.mem_addr_o;
        mon_a.data = bus.rdata_o;
      end else begin
        mon_hit = 1'b0;
      end
      if (mon_hit) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_event: kind %0d addr %h data %h, none required",
                   mon_a.kind, mon_a.addr, mon_a.data);
        end else begin
          mon_e = exp_q.pop_front();
          check("ev_kind", 64'(mon_a.kind), 64'(mon_e.kind));
          check("ev_addr", mon_a.addr, mon_e.addr);
          check("ev_data", mon_a.data, mon_e.data);
        end
      end
    end
  end

  function automatic logic [63:0] ref_dw(input logic [63:0] a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      v[8*i +: 8] = ref_mem[(int'(a[7:0]) + i) & 255];
    return v;
  endfunction

  // Issue one request, predict its bus event, run it to completion.
  task automatic op(input bit rd, input bit wr,
                    input logic [2:0] f3,
                    input logic [63:0] a,
                    input logic [63:0] wd,
                    input bit use_k,
                    input logic [63:0] k);
    ev_t         e;
    bit          bad;
    bit          s;
    int          nb;
    int          exp_stall;
    int          stalls;
    logic [63:0] v;
    logic [63:0] dw;
    bad = (rd && wr) || ((rd || wr) && a > 64'd248) ||
          (rd && f3 == 3'b111) || (wr && f3[2]);
    exp_stall = 0;
    nb = 1 << f3[1:0];
    e = '0;
    if (bad) begin
      e.kind = K_FAULT;
      exp_q.push_back(e);
    end else if (rd) begin
      dw = ref_dw(a);
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = dw[8*i +: 8];
      if (!f3[2] && nb < 8 && v[8*nb-1])
        v = v | ~((64'd1 << (8*nb)) - 64'd1);
      e.kind = K_LOAD;
      e.addr = a;
      e.data = use_k ? k : v;
      exp_q.push_back(e);
    end else if (wr) begin
      dw = ref_dw(a);
      for (int i = 0; i < nb; i++) dw[8*i +: 8] = wd[8*i +: 8];
      for (int i = 0; i < 8; i++)
        ref_mem[(int'(a[7:0]) + i) & 255] = dw[8*i +: 8];
      e.kind = K_WRITE;
      e.addr = a;
      e.data = use_k ? k : dw;
      exp_q.push_back(e);
      if (nb < 8) begin
        exp_stall = 1;
        if (exp_cnt != 16'hFFFF) exp_cnt++;
      end
    end
    bus.req_read_i  = rd;
    bus.req_write_i = wr;
    bus.funct3_i    = f3;
    bus.addr_i      = a;
    bus.wdata_i     = wd;
    stalls = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      s = bus.stall_o;
      stalls += int'(s);
      @(posedge clk_i);
      #1;
      if (!s) break;
    end
    stall_total += stalls;
    check("stall_cycles", 64'(stalls), 64'(exp_stall));
  endtask

  task automatic go_idle();
    bus.req_read_i  = 1'b0;
    bus.req_write_i = 1'b0;
  endtask

  initial begin
    logic [7:0]  b;
    logic [63:0] pre;
    int          st0;
    bit          rd;
    bit          wr;
    int          r;
    logic [63:0] a;

    pre = 64'h8877665544332211;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end
    for (int i = 0; i < 8; i++) begin
      mem[16+i] = pre[8*i +: 8];
      ref_mem[16+i] = pre[8*i +: 8];
    end
    bus.req_read_i  = 1'b0;
    bus.req_write_i = 1'b0;
    bus.funct3_i    = 3'b000;
    bus.addr_i      = '0;
    bus.wdata_i     = '0;

    #12;
    check("rst_stall", 64'(bus.stall_o), 64'd0);
    check("rst_read", 64'(bus.mem_read_o), 64'd0);
    check("rst_write", 64'(bus.mem_write_o), 64'd0);
    check("rst_fault", 64'(bus.fault_o), 64'd0);
    check("rst_cnt", 64'(bus.rmw_cnt_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // sh interrupted by reset while in the merge cycle
    bus.req_write_i = 1'b1;
    bus.funct3_i    = 3'b001;
    bus.addr_i      = 64'h30;
    bus.wdata_i     = 64'h1234;
    @(posedge clk_i);
    #1;
    check("merge_write", 64'(bus.mem_write_o), 64'd1);
    rst_i = 1'b0;
    #1;
    check("rstm_write", 64'(bus.mem_write_o), 64'd0);
    check("rstm_stall", 64'(bus.stall_o), 64'd0);
    check("rstm_cnt", 64'(bus.rmw_cnt_o), 64'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    go_idle();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rstm_cnt2", 64'(bus.rmw_cnt_o), 64'd0);
    op(1, 0, 3'b011, 64'h30, 0, 0, 0);

    op(1, 0, 3'b000, 64'h10, 0, 1, 64'h11);
    op(1, 0, 3'b001, 64'h17, 0, 0, 0);
    op(1, 0, 3'b010, 64'h14, 0, 1, 64'hFFFFFFFF88776655);
    op(1, 0, 3'b110, 64'h14, 0, 1, 64'h0000000088776655);
    op(0, 1, 3'b000, 64'h10, 64'hAB, 1, 64'h88776655443322AB);
    check("cnt_sb", 64'(bus.rmw_cnt_o), 64'd1);
    op(0, 1, 3'b011, 64'h20, 64'hDEADBEEFCAFEF00D, 0, 0);
    op(1, 0, 3'b011, 64'h20, 0, 1, 64'hDEADBEEFCAFEF00D);
    op(1, 0, 3'b011, 64'd249, 0, 0, 0);
    op(1, 0, 3'b111, 64'h10, 0, 0, 0);
    op(1, 1, 3'b011, 64'h10, 0, 0, 0);
    op(0, 1, 3'b100, 64'h10, 64'h5, 0, 0);
    op(1, 0, 3'b000, 64'hFFFFFFFFFFFFFF10, 0, 0, 0);
    op(1, 0, 3'b011, 64'd248, 0, 0, 0);
    op(0, 1, 3'b000, 64'd248, 64'h77, 0, 0);

    st0 = stall_total;
    op(0, 1, 3'b010, 64'h00, 64'h0123456789ABCDEF, 0, 0);
    op(0, 1, 3'b010, 64'h08, 64'hFEDCBA9876543210, 0, 0);
    check("b2b_stalls", 64'(stall_total - st0), 64'd2);
    check("b2b_cnt", 64'(bus.rmw_cnt_o), 64'(exp_cnt));
    op(1, 0, 3'b011, 64'h00, 0, 0, 0);
    op(1, 0, 3'b011, 64'h08, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 11));
      rd = (r <= 4) || (r == 9);
      wr = (r >= 5 && r <= 9);
      if ($urandom_range(0, 15) == 0) a = {$urandom, $urandom};
      else a = 64'($urandom_range(0, 255));
      op(rd, wr, 3'($urandom_range(0, 7)), a,
         {$urandom, $urandom}, 0, 0);
    end

    go_idle();
    repeat (3) @(posedge clk_i);
    #1;
    check("queue_left", 64'(exp_q.size()), 64'd0);
    check("final_cnt", 64'(bus.rmw_cnt_o), 64'(exp_cnt));
    for (int i = 0; i < 256; i += 8)
      check("mem_image",
            {mem[i+7], mem[i+6], mem[i+5], mem[i+4],
             mem[i+3], mem[i+2], mem[i+1], mem[i]},
            ref_dw(64'(i)));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
